// File: rtl/xy_pattern_detector_if.sv
// Signal bundle between the x/y signal generator and the 1101 pattern detector.
// The generator side drives x/y; the detector side drives the match/status outputs.
interface xy_pattern_detector_if #(
    parameter int COUNT_W = 8
);
    logic               x;
    logic               y;
    logic               match;
    logic [COUNT_W-1:0] match_count;
    logic [0:4]         state_led;
    logic               det_led;

    modport master (
        output x,
        output y,
        input  match,
        input  match_count,
        input  state_led,
        input  det_led
    );

    modport slave (
        input  x,
        input  y,
        output match,
        output match_count,
        output state_led,
        output det_led
    );
endinterface

// File: rtl/xy_pattern_detector.sv
// Moore detector for the overlapping serial sequence 1-1-0-1, sampling x only when y=1.
// Produces a match pulse, a wrapping match count, one-hot state LEDs and a stretched detect LED.
module xy_pattern_detector #(
    parameter int COUNT_W     = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    xy_pattern_detector_if.slave  bus
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic               match_nxt;
    logic [0:4]         led_nxt;
    logic               match_q;
    logic [COUNT_W-1:0] count_q;
    logic [0:4]         led_q;
    logic [HOLD_W-1:0]  hold_q;

    always_comb begin
        state_nxt = state_q;
        match_nxt = 1'b0;
        if (bus.y) begin
            unique case (state_q)
                S0: state_nxt = bus.x ? S1 : S0;
                S1: state_nxt = bus.x ? S2 : S0;
                S2: state_nxt = bus.x ? S2 : S3;
                S3: begin
                    state_nxt = bus.x ? S4 : S0;
                    match_nxt = bus.x;
                end
                // Trailing "1" of a match is also the first "1" of the next one
                S4:      state_nxt = bus.x ? S2 : S0;
                default: state_nxt = S0;
            endcase
        end
    end

    always_comb begin
        led_nxt = 5'b10000;
        unique case (state_nxt)
            S0:      led_nxt = 5'b10000;
            S1:      led_nxt = 5'b01000;
            S2:      led_nxt = 5'b00100;
            S3:      led_nxt = 5'b00010;
            S4:      led_nxt = 5'b00001;
            default: led_nxt = 5'b10000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S0;
            match_q <= 1'b0;
            count_q <= '0;
            led_q   <= 5'b10000;
            hold_q  <= '0;
        end else begin
            state_q <= state_nxt;
            match_q <= match_nxt;
            led_q   <= led_nxt;
            if (match_nxt) begin
                count_q <= count_q + COUNT_W'(1);
            end
            // Retrigger reloads the hold so back-to-back matches keep the LED lit
            if (match_nxt) begin
                hold_q <= HOLD_W'(HOLD_CYCLES);
            end else if (hold_q != '0) begin
                hold_q <= hold_q - HOLD_W'(1);
            end
        end
    end

    assign bus.match       = match_q;
    assign bus.match_count = count_q;
    assign bus.state_led   = led_q;
    assign bus.det_led     = (hold_q != '0);
endmodule

// File: tb/tb_xy_pattern_detector.sv
// Bench for xy_pattern_detector: directed vector table, hand-written corner sequences and
// randomized traffic against a suffix-matching reference model; two DUTs (COUNT_W=8 and 2).
module tb_xy_pattern_detector;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic x_r = 1'b0;
    logic y_r = 1'b0;

    always #5 clk = ~clk;

    xy_pattern_detector_if #(.COUNT_W(8)) bus8 ();
    xy_pattern_detector_if #(.COUNT_W(2)) bus2 ();

    assign bus8.x = x_r;
    assign bus8.y = y_r;
    assign bus2.x = x_r;
    assign bus2.y = y_r;

    xy_pattern_detector #(.COUNT_W(8), .HOLD_CYCLES(HOLD)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    xy_pattern_detector #(.COUNT_W(2), .HOLD_CYCLES(HOLD)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model: sampled bit history and derived quantities
    logic [3:0] m_hist;
    int         m_nsamp;
    int         m_k;
    int         m_count;
    int         m_hold;
    bit         m_match;

    typedef struct {
        logic       r;
        logic       x;
        logic       y;
        logic       m;
        logic [4:0] led;
        logic [7:0] cnt;
        logic       det;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Longest suffix of the sampled stream that is a prefix of 1101
    function automatic int prefix_len(input logic [3:0] hist, input int nsamp);
        int pat[4] = '{1, 1, 0, 1};
        for (int k = 4; k >= 1; k--) begin
            bit ok = (nsamp >= k);
            for (int j = 0; j < k; j++) begin
                if (int'(hist[k-1-j]) != pat[j]) ok = 0;
            end
            if (ok) return k;
        end
        return 0;
    endfunction

    task automatic model_update(input logic r, input logic xi, input logic yi);
        if (!r) begin
            m_hist  = '0;
            m_nsamp = 0;
            m_k     = 0;
            m_count = 0;
            m_hold  = 0;
            m_match = 0;
        end else begin
            m_match = 0;
            if (yi) begin
                m_hist  = {m_hist[2:0], xi};
                m_nsamp = m_nsamp + 1;
                m_k     = prefix_len(m_hist, m_nsamp);
                m_match = (m_k == 4);
                if (m_match) m_count = m_count + 1;
            end
            if (m_match) m_hold = HOLD;
            else if (m_hold > 0) m_hold = m_hold - 1;
        end
    endtask

    task automatic step(input logic r, input logic xi, input logic yi);
        @(negedge clk);
        reset = r;
        x_r   = xi;
        y_r   = yi;
        @(posedge clk);
        model_update(r, xi, yi);
        #1;
        if (bus8.match === 1'b1) pulses++;
        chk("model.match8", 32'(bus8.match), 32'(m_match));
        chk("model.led8", 32'(bus8.state_led), 32'(5'b10000 >> m_k));
        chk("model.count8", 32'(bus8.match_count), 32'(m_count % 256));
        chk("model.det8", 32'(bus8.det_led), 32'(m_hold > 0));
        chk("model.match2", 32'(bus2.match), 32'(m_match));
        chk("model.led2", 32'(bus2.state_led), 32'(5'b10000 >> m_k));
        chk("model.count2", 32'(bus2.match_count), 32'(m_count % 4));
        chk("model.det2", 32'(bus2.det_led), 32'(m_hold > 0));
    endtask

    task automatic add(input logic r, input logic xi, input logic yi, input logic m,
                       input logic [4:0] led, input logic [7:0] cnt, input logic det);
        vec_t v;
        v.r = r; v.x = xi; v.y = yi; v.m = m; v.led = led; v.cnt = cnt; v.det = det;
        tbl.push_back(v);
    endtask

    task automatic pattern_1101();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        int wrap_exp[5];
        wrap_exp = '{1, 2, 3, 0, 1};

        //    r     x     y     m     led        cnt   det
        add(1'b1, 1'b0, 1'b0, 1'b0, 5'b10000, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 5'b01000, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 5'b00100, 8'd0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 5'b00001, 8'd1, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 5'b00001, 8'd1, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 5'b00001, 8'd1, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 5'b00001, 8'd1, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 5'b00001, 8'd1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 5'b10000, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 5'b01000, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 5'b00100, 8'd0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 5'b00001, 8'd1, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 5'b00100, 8'd1, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 8'd1, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b1, 5'b00001, 8'd2, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 5'b00001, 8'd2, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 5'b00001, 8'd2, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 5'b00001, 8'd2, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 5'b00001, 8'd2, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 5'b00100, 8'd2, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 8'd2, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 5'b10000, 8'd0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 5'b01000, 8'd0, 1'b0);

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].x, tbl[i].y);
            chk($sformatf("vec%0d.match", i), 32'(bus8.match), 32'(tbl[i].m));
            chk($sformatf("vec%0d.led", i), 32'(bus8.state_led), 32'(tbl[i].led));
            chk($sformatf("vec%0d.count8", i), 32'(bus8.match_count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d.count2", i), 32'(bus2.match_count), 32'(tbl[i].cnt[1:0]));
            chk($sformatf("vec%0d.det", i), 32'(bus8.det_led), 32'(tbl[i].det));
        end

        // Qualifier gaps: x toggles freely while y=0
        step(1'b0, 1'b0, 1'b0);
        pulses = 0;
        begin
            logic [3:0] bits;
            bits = 4'b1101;
            for (int b = 3; b >= 0; b--) begin
                step(1'b1, bits[b], 1'b1);
                for (int g = 0; g < 3; g++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        chk("gap.count", 32'(bus8.match_count), 32'd1);
        chk("gap.pulses", 32'(pulses), 32'd1);
        chk("gap.led", 32'(bus8.state_led), 32'(5'b00001));

        // Wrap of the 2-bit counter over five separate patterns
        step(1'b0, 1'b0, 1'b0);
        pulses = 0;
        for (int p = 0; p < 5; p++) begin
            pattern_1101();
            chk($sformatf("wrap%0d.count2", p), 32'(bus2.match_count), 32'(wrap_exp[p]));
            step(1'b1, 1'b0, 1'b1);
        end
        chk("wrap.pulses", 32'(pulses), 32'd5);
        chk("wrap.count8", 32'(bus8.match_count), 32'd5);

        // Randomized traffic with occasional resets
        step(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            step(1'($urandom_range(0, 63) != 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
